// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Kept at least one bit wide so a single-step configuration still has a legal counter.
  function automatic int cnt_width(input int width, input int bits_per_cycle);
    int n;
    n = width / bits_per_cycle;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One datapath step: multiplicand times one multiplier digit, aligned to the digit
// position and added into the double-width accumulator.
module seq_mult_step #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CW             = 6
) (
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  input  logic [CW-1:0]             count,
  input  logic [2*WIDTH-1:0]        acc,
  output logic [2*WIDTH-1:0]        acc_next
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int SW = 16;

  logic [PW-1:0] pp;
  logic [PW-1:0] sum;
  logic [SW-1:0] shamt;
  logic          unused_carry;

  always_comb begin
    shamt = SW'(count) * SW'(BITS_PER_CYCLE);
    pp    = (PW'(mcand) * PW'(digit)) << shamt;
    sum   = {1'b0, acc} + pp;
  end

  // The partial sum never exceeds a*b < 2^(2*WIDTH), so the carry bit is always zero.
  assign {unused_carry, acc_next} = sum;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Optional SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N  = num_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);

  generate
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_param_check
      $fatal(1, "seq_multiplier: BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CW-1:0]        count;
  logic                 last_step;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_step = (count == CW'(N - 1)) || ((mplier >> BITS_PER_CYCLE) == '0);
`else
  assign last_step = (count == CW'(N - 1));
`endif

  seq_mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CW             (CW)
  ) u_step (
    .mcand    (mcand),
    .digit    (mplier[BITS_PER_CYCLE-1:0]),
    .count    (count),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> BITS_PER_CYCLE;
          count  <= last_step ? '0 : count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // The accumulator holds the finished product for the whole DONE state.
  assign product = acc;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed cases plus randomised back-to-back operands over
// several widths and digit sizes, checked against plain a*b and a digit-count latency model.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [5:0]   in_valid;
  logic [5:0]   out_ready;
  logic [5:0]   in_ready_o;
  logic [5:0]   out_valid_o;
  logic [5:0]   busy_o;
  logic [63:0]  a_in;
  logic [63:0]  b_in;
  logic [127:0] prod_o [6];
  logic [15:0]  p8;
  logic [127:0] p64;

  int tests = 0;
  int fails = 0;

  seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_o[0]),
    .a(a_in[7:0]), .b(b_in[7:0]), .out_valid(out_valid_o[0]), .out_ready(out_ready[0]),
    .product(p8), .busy(busy_o[0])
  );
  assign prod_o[0] = {112'b0, p8};

  seq_multiplier #(.WIDTH(64), .BITS_PER_CYCLE(4)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_o[1]),
    .a(a_in), .b(b_in), .out_valid(out_valid_o[1]), .out_ready(out_ready[1]),
    .product(p64), .busy(busy_o[1])
  );
  assign prod_o[1] = p64;

  for (genvar g = 0; g < 4; g++) begin : g_w16
    logic [31:0] p16;
    seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid[2+g]), .in_ready(in_ready_o[2+g]),
      .a(a_in[15:0]), .b(b_in[15:0]), .out_valid(out_valid_o[2+g]), .out_ready(out_ready[2+g]),
      .product(p16), .busy(busy_o[2+g])
    );
    assign prod_o[2+g] = {96'b0, p16};
  end

  function automatic int w_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 64 : 16;
  endfunction

  function automatic int bpc_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : (1 << (k - 2));
  endfunction

  // Cycle (counting the accept edge as 0) in which out_valid first rises.
  function automatic int exp_lat(input int k, input logic [63:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int d;
    logic [63:0] t;
    d = 0;
    t = b;
    while (t != 0) begin
      t = t >> bpc_of(k);
      d++;
    end
    if (d == 0) d = 1;
    return d + 1;
`else
    return w_of(k) / bpc_of(k) + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge with the DUT expected idle; hold = cycles of backpressure.
  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        input int hold, input string tag);
    logic [127:0] exp;
    int cyc;
    exp = {64'b0, a} * {64'b0, b};
    a_in = a;
    b_in = b;
    in_valid[k]  = 1'b1;
    out_ready[k] = (hold == 0);
    check({tag, "/in_ready_idle"}, 128'(in_ready_o[k]), 128'(1));
    @(negedge clk);
    in_valid[k] = 1'b0;
    a_in = {$urandom, $urandom};
    b_in = {$urandom, $urandom};
    cyc = 1;
    while (!out_valid_o[k] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 128'(cyc), 128'(exp_lat(k, b)));
    check({tag, "/product"}, prod_o[k], exp);
    for (int i = 0; i < hold; i++) begin
      check({tag, "/hold_valid"}, 128'(out_valid_o[k]), 128'(1));
      check({tag, "/hold_product"}, prod_o[k], exp);
      check({tag, "/hold_in_ready"}, 128'(in_ready_o[k]), 128'(0));
      a_in = {$urandom, $urandom};
      @(negedge clk);
    end
    if (hold > 0) begin
      out_ready[k] = 1'b1;
      check({tag, "/handshake_valid"}, 128'(out_valid_o[k]), 128'(1));
    end
    @(negedge clk);
    out_ready[k] = 1'b0;
    check({tag, "/post_valid_low"}, 128'(out_valid_o[k]), 128'(0));
    check({tag, "/post_in_ready"}, 128'(in_ready_o[k]), 128'(1));
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int          hold;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("reset/in_ready", 128'(in_ready_o[k]), 128'(1));
      check("reset/out_valid", 128'(out_valid_o[k]), 128'(0));
      check("reset/busy", 128'(busy_o[k]), 128'(0));
      check("reset/product", prod_o[k], 128'(0));
    end

    run_op(0, 64'd255, 64'd255, 0, "w8_255x255");
    check("w8_255x255/const", prod_o[0], 128'h0000_FE01);
    run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, "w64_max_x2");
    check("w64_max_x2/const", prod_o[1], 128'h1_FFFF_FFFF_FFFF_FFFE);
    run_op(0, 64'd12, 64'd10, 5, "w8_backpressure");
    check("w8_backpressure/const", prod_o[0], 128'd120);

    // Abort an operation while it is still running.
    a_in = 64'd200;
    b_in = 64'd100;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid/busy_before", 128'(busy_o[0]), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid/out_valid", 128'(out_valid_o[0]), 128'(0));
    check("rst_mid/product", prod_o[0], 128'(0));
    check("rst_mid/busy", 128'(busy_o[0]), 128'(0));
    check("rst_mid/in_ready", 128'(in_ready_o[0]), 128'(1));
    rst = 1'b0;
    run_op(0, 64'd3, 64'd7, 0, "w8_after_rst");
    check("w8_after_rst/const", prod_o[0], 128'd21);

    run_op(2, 64'd1234, 64'd0, 0, "w16_b0");
    run_op(2, 64'd1234, 64'd1, 0, "w16_b1");
    run_op(2, 64'hFFFF, 64'hFFFF, 2, "w16_max");

    for (int k = 2; k < 6; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 64'($urandom_range(0, 16'hFFFF));
        case ($urandom_range(0, 3))
          0:       rb = 64'($urandom_range(0, 15));
          1:       rb = 64'($urandom_range(0, 255));
          default: rb = 64'($urandom_range(0, 16'hFFFF));
        endcase
        hold = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
        run_op(k, ra, rb, hold, "w16_random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
